endpoint_lookup_probe: RTL and testbench
========================================

# endpoint_lookup_probe

Parametrised IP-to-MAC endpoint resolver for the RDMA TX path, sitting between the header builder and the endpoint table BRAM (port B). It hashes the destination IP into a table index and linearly probes up to `MAX_PROBES` consecutive slots to resolve hash collisions. BRAM read latency is configurable. Requests and responses use valid/ready handshakes with a tag passthrough, and the block keeps hit/miss statistics.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: table index width, legal range 8..24.
- `BRAM_DATA_WIDTH`, 256: entry width, must be at least 160.
- `BRAM_LATENCY`, 1: cycles from `bram_en` to valid `bram_dout`, legal range 1..3.
- `MAX_PROBES`, 4: slots examined per lookup, legal range 1..16.
- `TAG_WIDTH`, 4: width of the opaque request tag.
- Any out-of-range parameter is an elaboration error.

Ports:
- Reset `rstn` is synchronous and active-low; the clock is `clk`.
- `clk` in 1: clock.
- `rstn` in 1: synchronous active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_ip` in 32: destination IP.
- `req_tag` in `TAG_WIDTH`: tag returned unchanged on the response.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_hit` out 1: 1 = matching entry found.
- `rsp_status` out 2: 00 hit, 01 empty slot reached, 10 probe limit exhausted.
- `rsp_probes` out `PW` = $clog2(`MAX_PROBES`+1): number of slots read.
- `rsp_tag` out `TAG_WIDTH`: copy of the request tag.
- `rsp_dst_mac`, `rsp_src_mac` out 48 each: MACs, zero unless hit.
- `bram_addr` out `ADDR_WIDTH`, `bram_en` out 1: BRAM read request.
- `bram_dout` in `BRAM_DATA_WIDTH`: BRAM read data.
- `stat_clear` in 1: synchronous clear of both statistics counters.
- `stat_hits`, `stat_misses` out 32 each: saturating counters.

## Operation
- Entry layout, with W = `BRAM_DATA_WIDTH`, MSB-first:
  - valid at bit [W-1]; bits [W-2:W-32] reserved;
  - IP at [W-33:W-64];
  - dst_mac at [W-65:W-112];
  - src_mac at [W-113:W-160].
- Home index = `req_ip`[AW-1:0] XOR `req_ip`[AW+7:8].
- Probe k (counting from 0) reads address (home + k) mod 2^AW, so addresses wrap from all-ones to 0.
- States are IDLE, ISSUE, WAIT, EVAL and RESP.
- IDLE: `req_ready`=1. On handshake, latch IP, tag and home index, clear the probe count, go to ISSUE.
- ISSUE: `bram_en`=1 with the current address for exactly this one cycle. Go to EVAL if `BRAM_LATENCY`=1, else to WAIT.
- WAIT: hold for `BRAM_LATENCY`-1 cycles, then go to EVAL.
- EVAL: sample `bram_dout` and increment the probe count. Evaluate in this order:
  - valid=0: status 01, go to RESP.
  - valid=1 and IP matches: hit, latch both MACs, status 00, go to RESP.
  - otherwise, if count equals `MAX_PROBES`: status 10, go to RESP.
  - otherwise: address+1, go to ISSUE.
- RESP: `rsp_valid`=1 and all `rsp_*` outputs stay stable until `rsp_ready`. On handshake, go to IDLE.
- Statistics update on the response handshake only: a hit increments `stat_hits`; status 01 or 10 increments `stat_misses`. Both saturate at 0xFFFFFFFF.
- If `stat_clear` and an increment land in the same cycle, clear wins and the counter reads 0.

## Timing
- Reset values: `req_ready`=1; `rsp_valid`, `rsp_hit`, `bram_en`=0; `rsp_status`, `rsp_probes`, `rsp_tag`, MACs, `bram_addr`, stats all 0.
- Let T be the request-accept cycle and L = `BRAM_LATENCY`. `rsp_valid` rises at T + 1 + k·(L+1), where k is the number of probes used.
- `req_ready` is 0 from T+1 until the cycle after the response handshake. No request is accepted in the same cycle as a response handshake.
- `bram_en` is a one-cycle pulse per probe; outside ISSUE it is 0.
- Reset in any state:
  - discards the in-flight request;
  - `bram_en` and `rsp_valid` go to 0 next cycle;
  - no statistics update occurs, and counters return to 0.

## Structure
- Package `endpoint_lookup_pkg` holds:
  - the status codes ST_HIT, ST_EMPTY, ST_LIMIT;
  - the state enum;
  - functions for entry field offsets as a function of W.
- One sub-module, `lookup_stat_counter`: 32-bit saturating counter with increment and synchronous clear (clear wins). It is instantiated twice.

## Test plan
1. Direct hit. Settings: AW=11, L=1. Slot 0x005 is valid with IP 0x0A000005, dst 0x001122334455, src 0x66778899AABB. Request `req_ip`=0x0A000005, tag 0x3. Expect: hit=1, status 00, probes 1, tag 0x3, MACs as stored, `rsp_valid` at T+3.
2. Collision. Slot 0x005 holds IP 0x0A000805; slot 0x006 holds the target. Expect: `bram_addr` sequence 0x005, 0x006; hit, probes 2, `rsp_valid` at T+5.
3. Empty. Slot 0x005 is valid but mismatched; slot 0x006 has valid=0. Expect: hit=0, status 01, probes 2, MACs 0, `stat_misses` +1.
4. Wrap and limit. `req_ip`=0x0007F807 (home 0x7FF), `MAX_PROBES`=4. Slots 0x7FF, 0x000, 0x001, 0x002 are valid and mismatched. Expect: addresses in that order, status 10, probes 4.
5. Backpressure and stats. Hold `rsp_ready` low for 5 cycles. Expect: outputs stable, `req_ready`=0, `stat_hits` +1 exactly once. Then repeat with `stat_clear` in the handshake cycle: expect both counters at 0.
6. Reset mid-probe. With L=3, drop `rstn` during WAIT. Expect: `bram_en`=0, `rsp_valid`=0, `req_ready`=1 after release, stats 0. A fresh lookup then completes normally.

Source files
------------

// File: rtl/endpoint_lookup_pkg.sv
// Shared definitions for the endpoint lookup block: status codes, FSM states
// and the entry field layout within a table word of width W.
package endpoint_lookup_pkg;

  localparam logic [1:0] ST_HIT   = 2'b00;
  localparam logic [1:0] ST_EMPTY = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;

  localparam int ENTRY_MIN_W = 160;
  localparam int IP_W        = 32;
  localparam int MAC_W       = 48;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Entry fields are packed from the MSB down; these return LSB positions.
  function automatic int valid_pos(input int w);
    return w - 1;
  endfunction

  function automatic int ip_lsb(input int w);
    return w - 64;
  endfunction

  function automatic int dst_lsb(input int w);
    return w - 112;
  endfunction

  function automatic int src_lsb(input int w);
    return w - 160;
  endfunction

endpackage

// File: rtl/lookup_stat_counter.sv
// 32-bit saturating event counter with synchronous clear; clear beats increment.
module lookup_stat_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  // Count events, hold at all-ones, and zero on reset or clear.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/endpoint_lookup_probe.sv
// IP-to-MAC endpoint resolver. Hashes the destination IP into a table index
// and linearly probes consecutive BRAM slots until a match, an empty slot,
// or the probe limit. One outstanding request at a time.
module endpoint_lookup_probe
  import endpoint_lookup_pkg::*;
#(
  parameter int ADDR_WIDTH      = 11,
  parameter int BRAM_DATA_WIDTH = 256,
  parameter int BRAM_LATENCY    = 1,
  parameter int MAX_PROBES      = 4,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [31:0]                       req_ip,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_hit,
  output logic [1:0]                        rsp_status,
  output logic [$clog2(MAX_PROBES+1)-1:0]   rsp_probes,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic [47:0]                       rsp_dst_mac,
  output logic [47:0]                       rsp_src_mac,
  output logic [ADDR_WIDTH-1:0]             bram_addr,
  output logic                              bram_en,
  input  logic [BRAM_DATA_WIDTH-1:0]        bram_dout,
  input  logic                              stat_clear,
  output logic [31:0]                       stat_hits,
  output logic [31:0]                       stat_misses
);

  localparam int PW        = $clog2(MAX_PROBES + 1);
  localparam int VALID_POS = valid_pos(BRAM_DATA_WIDTH);
  localparam int IP_LSB    = ip_lsb(BRAM_DATA_WIDTH);
  localparam int DST_LSB   = dst_lsb(BRAM_DATA_WIDTH);
  localparam int SRC_LSB   = src_lsb(BRAM_DATA_WIDTH);
  localparam logic [PW-1:0] MAXP      = PW'(MAX_PROBES);
  localparam logic [1:0]    WAIT_LAST = 2'(BRAM_LATENCY - 2);

  // Reject illegal configurations at elaboration time.
  if (ADDR_WIDTH < 8 || ADDR_WIDTH > 24) begin : g_bad_addr_width
    $error("endpoint_lookup_probe: ADDR_WIDTH must be 8..24");
  end
  if (BRAM_DATA_WIDTH < ENTRY_MIN_W) begin : g_bad_data_width
    $error("endpoint_lookup_probe: BRAM_DATA_WIDTH must be >= 160");
  end
  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 3) begin : g_bad_latency
    $error("endpoint_lookup_probe: BRAM_LATENCY must be 1..3");
  end
  if (MAX_PROBES < 1 || MAX_PROBES > 16) begin : g_bad_probes
    $error("endpoint_lookup_probe: MAX_PROBES must be 1..16");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("endpoint_lookup_probe: TAG_WIDTH must be >= 1");
  end

  state_t                state;
  state_t                state_next;
  logic [31:0]           ip_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PW-1:0]         probe_cnt;
  logic [PW-1:0]         probe_inc;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] home;
  logic                  entry_valid;
  logic [IP_W-1:0]       entry_ip;
  logic [MAC_W-1:0]      entry_dst;
  logic [MAC_W-1:0]      entry_src;
  logic                  ip_match;
  logic                  probe_last;
  logic                  rsp_fire;
  logic                  unused_dout;

  // Hash folds the second address-wide byte window onto the low bits.
  assign home        = req_ip[ADDR_WIDTH-1:0] ^ req_ip[ADDR_WIDTH+7:8];
  assign entry_valid = bram_dout[VALID_POS];
  assign entry_ip    = bram_dout[IP_LSB +: IP_W];
  assign entry_dst   = bram_dout[DST_LSB +: MAC_W];
  assign entry_src   = bram_dout[SRC_LSB +: MAC_W];
  assign ip_match    = entry_valid && (entry_ip == ip_q);
  assign probe_inc   = probe_cnt + 1'b1;
  assign probe_last  = (probe_inc == MAXP);
  assign rsp_fire    = (state == S_RESP) && rsp_ready;
  // Reserved and padding bits of the entry are deliberately ignored.
  assign unused_dout = ^bram_dout;

  assign rsp_tag    = tag_q;
  assign rsp_probes = probe_cnt;
  assign bram_addr  = addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: issue, wait out BRAM latency, evaluate, respond.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = S_ISSUE;
      S_ISSUE: state_next = (BRAM_LATENCY == 1) ? S_EVAL : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_next = S_EVAL;
      S_EVAL: begin
        if (!entry_valid || ip_match || probe_last) begin
          state_next = S_RESP;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and BRAM strobe decode purely from the current state.
  always_comb begin
    req_ready = (state == S_IDLE);
    bram_en   = (state == S_ISSUE);
    rsp_valid = (state == S_RESP);
  end

  // Request capture, probe walk and result latching.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ip_q        <= '0;
      tag_q       <= '0;
      addr_q      <= '0;
      probe_cnt   <= '0;
      wait_cnt    <= '0;
      rsp_hit     <= 1'b0;
      rsp_status  <= ST_HIT;
      rsp_dst_mac <= '0;
      rsp_src_mac <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            ip_q      <= req_ip;
            tag_q     <= req_tag;
            addr_q    <= home;
            probe_cnt <= '0;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 2'd1;
        S_EVAL: begin
          probe_cnt <= probe_inc;
          if (!entry_valid) begin
            rsp_hit     <= 1'b0;
            rsp_status  <= ST_EMPTY;
            rsp_dst_mac <= '0;
            rsp_src_mac <= '0;
          end else if (ip_match) begin
            rsp_hit     <= 1'b1;
            rsp_status  <= ST_HIT;
            rsp_dst_mac <= entry_dst;
            rsp_src_mac <= entry_src;
          end else if (probe_last) begin
            rsp_hit     <= 1'b0;
            rsp_status  <= ST_LIMIT;
            rsp_dst_mac <= '0;
            rsp_src_mac <= '0;
          end else begin
            // Natural AW-bit overflow gives the wrap from all-ones to zero.
            addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lookup_stat_counter u_hits (
    .clk   (clk),
    .rstn  (rstn),
    .clear (stat_clear),
    .inc   (rsp_fire && rsp_hit),
    .count (stat_hits)
  );

  lookup_stat_counter u_misses (
    .clk   (clk),
    .rstn  (rstn),
    .clear (stat_clear),
    .inc   (rsp_fire && !rsp_hit),
    .count (stat_misses)
  );

endmodule

// File: tb/tb_endpoint_lookup_probe.sv
// Directed bench for endpoint_lookup_probe: one instance at BRAM latency 1,
// one at latency 3, sharing a behavioural endpoint table.
module tb_endpoint_lookup_probe;

  localparam int AW = 11;
  localparam int W  = 256;
  localparam int TW = 4;
  localparam int MP = 4;
  localparam int PW = $clog2(MP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (latency 1)
  logic          rstn_a = 1'b0, req_valid_a = 1'b0, rsp_ready_a = 1'b0, stat_clear_a = 1'b0;
  logic [31:0]   req_ip_a = '0;
  logic [TW-1:0] req_tag_a = '0;
  logic          req_ready_a, rsp_valid_a, rsp_hit_a, bram_en_a;
  logic [1:0]    rsp_status_a;
  logic [PW-1:0] rsp_probes_a;
  logic [TW-1:0] rsp_tag_a;
  logic [47:0]   rsp_dst_mac_a, rsp_src_mac_a;
  logic [AW-1:0] bram_addr_a;
  logic [W-1:0]  bram_dout_a = '0;
  logic [31:0]   stat_hits_a, stat_misses_a;

  // Instance B (latency 3)
  logic          rstn_b = 1'b0, req_valid_b = 1'b0, rsp_ready_b = 1'b0, stat_clear_b = 1'b0;
  logic [31:0]   req_ip_b = '0;
  logic [TW-1:0] req_tag_b = '0;
  logic          req_ready_b, rsp_valid_b, rsp_hit_b, bram_en_b;
  logic [1:0]    rsp_status_b;
  logic [PW-1:0] rsp_probes_b;
  logic [TW-1:0] rsp_tag_b;
  logic [47:0]   rsp_dst_mac_b, rsp_src_mac_b;
  logic [AW-1:0] bram_addr_b;
  logic [W-1:0]  bram_dout_b = '0;
  logic [W-1:0]  b_d1 = '0, b_d2 = '0;
  logic [31:0]   stat_hits_b, stat_misses_b;

  endpoint_lookup_probe #(.ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(W), .BRAM_LATENCY(1),
                          .MAX_PROBES(MP), .TAG_WIDTH(TW)) dut_a (
    .clk(clk), .rstn(rstn_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_ip(req_ip_a), .req_tag(req_tag_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_hit(rsp_hit_a), .rsp_status(rsp_status_a), .rsp_probes(rsp_probes_a),
    .rsp_tag(rsp_tag_a), .rsp_dst_mac(rsp_dst_mac_a), .rsp_src_mac(rsp_src_mac_a),
    .bram_addr(bram_addr_a), .bram_en(bram_en_a), .bram_dout(bram_dout_a),
    .stat_clear(stat_clear_a), .stat_hits(stat_hits_a), .stat_misses(stat_misses_a));

  endpoint_lookup_probe #(.ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(W), .BRAM_LATENCY(3),
                          .MAX_PROBES(MP), .TAG_WIDTH(TW)) dut_b (
    .clk(clk), .rstn(rstn_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_ip(req_ip_b), .req_tag(req_tag_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_hit(rsp_hit_b), .rsp_status(rsp_status_b), .rsp_probes(rsp_probes_b),
    .rsp_tag(rsp_tag_b), .rsp_dst_mac(rsp_dst_mac_b), .rsp_src_mac(rsp_src_mac_b),
    .bram_addr(bram_addr_b), .bram_en(bram_en_b), .bram_dout(bram_dout_b),
    .stat_clear(stat_clear_b), .stat_hits(stat_hits_b), .stat_misses(stat_misses_b));

  // Behavioural endpoint table
  logic [W-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bram_en_a) bram_dout_a <= mem[bram_addr_a];
  end

  always @(posedge clk) begin
    if (bram_en_b) b_d1 <= mem[bram_addr_b];
    b_d2        <= b_d1;
    bram_dout_b <= b_d2;
  end

  int n_checks = 0;
  int n_fails  = 0;
  int lat;
  logic [AW-1:0] seen [$];

  function automatic logic [W-1:0] ent(input logic v, input logic [31:0] ip,
                                       input logic [47:0] d, input logic [47:0] s);
    ent = {v, 31'd0, ip, d, s, 96'd0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on A and run until rsp_valid; lat = cycles after accept.
  task automatic lookup_a(input logic [31:0] ip, input logic [TW-1:0] tag);
    req_ip_a = ip; req_tag_a = tag; req_valid_a = 1'b1;
    chk("a_req_ready_idle", req_ready_a, 1);
    tick;
    req_valid_a = 1'b0;
    lat = 1;
    seen.delete();
    chk("a_req_ready_busy", req_ready_a, 0);
    while (!rsp_valid_a && lat < 60) begin
      if (bram_en_a) seen.push_back(bram_addr_a);
      tick;
      lat++;
    end
    chk("a_rsp_valid_seen", rsp_valid_a, 1);
  endtask

  task automatic ack_a(input logic clr);
    rsp_ready_a = 1'b1; stat_clear_a = clr;
    tick;
    rsp_ready_a = 1'b0; stat_clear_a = 1'b0;
    chk("a_rsp_valid_after_ack", rsp_valid_a, 0);
    chk("a_req_ready_after_ack", req_ready_a, 1);
  endtask

  task automatic lookup_b(input logic [31:0] ip, input logic [TW-1:0] tag);
    req_ip_b = ip; req_tag_b = tag; req_valid_b = 1'b1;
    tick;
    req_valid_b = 1'b0;
    lat = 1;
    while (!rsp_valid_b && lat < 60) begin
      tick;
      lat++;
    end
    chk("b_rsp_valid_seen", rsp_valid_b, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset values
    repeat (3) tick;
    chk("rst_req_ready", req_ready_a, 1);
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_rsp_hit", rsp_hit_a, 0);
    chk("rst_bram_en", bram_en_a, 0);
    chk("rst_status", rsp_status_a, 0);
    chk("rst_probes", rsp_probes_a, 0);
    chk("rst_tag", rsp_tag_a, 0);
    chk("rst_dst", rsp_dst_mac_a, 0);
    chk("rst_src", rsp_src_mac_a, 0);
    chk("rst_addr", bram_addr_a, 0);
    chk("rst_hits", stat_hits_a, 0);
    chk("rst_misses", stat_misses_a, 0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    tick;

    // 1: direct hit at home slot 0x005
    mem[5] = ent(1'b1, 32'h0A00_0005, 48'h0011_2233_4455, 48'h6677_8899_AABB);
    lookup_a(32'h0A00_0005, 4'h3);
    chk("t1_latency", lat, 3);
    chk("t1_nprobe_en", seen.size(), 1);
    chk("t1_addr0", seen[0], 11'h005);
    chk("t1_hit", rsp_hit_a, 1);
    chk("t1_status", rsp_status_a, 2'b00);
    chk("t1_probes", rsp_probes_a, 1);
    chk("t1_tag", rsp_tag_a, 4'h3);
    chk("t1_dst", rsp_dst_mac_a, 48'h0011_2233_4455);
    chk("t1_src", rsp_src_mac_a, 48'h6677_8899_AABB);
    ack_a(1'b0);
    chk("t1_hits", stat_hits_a, 1);
    chk("t1_misses", stat_misses_a, 0);

    // 2: collision, target one slot past home
    mem[5] = ent(1'b1, 32'h0A00_0805, 48'hDEAD_0000_0001, 48'hBEEF_0000_0001);
    mem[6] = ent(1'b1, 32'h0A00_0005, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6);
    lookup_a(32'h0A00_0005, 4'h7);
    chk("t2_latency", lat, 5);
    chk("t2_nprobe_en", seen.size(), 2);
    chk("t2_addr0", seen[0], 11'h005);
    chk("t2_addr1", seen[1], 11'h006);
    chk("t2_hit", rsp_hit_a, 1);
    chk("t2_status", rsp_status_a, 2'b00);
    chk("t2_probes", rsp_probes_a, 2);
    chk("t2_tag", rsp_tag_a, 4'h7);
    chk("t2_dst", rsp_dst_mac_a, 48'hA1A2_A3A4_A5A6);
    chk("t2_src", rsp_src_mac_a, 48'hB1B2_B3B4_B5B6);
    ack_a(1'b0);
    chk("t2_hits", stat_hits_a, 2);

    // 3: empty slot terminates the walk
    mem[6] = '0;
    lookup_a(32'h0A00_0005, 4'h1);
    chk("t3_latency", lat, 5);
    chk("t3_hit", rsp_hit_a, 0);
    chk("t3_status", rsp_status_a, 2'b01);
    chk("t3_probes", rsp_probes_a, 2);
    chk("t3_dst", rsp_dst_mac_a, 0);
    chk("t3_src", rsp_src_mac_a, 0);
    ack_a(1'b0);
    chk("t3_misses", stat_misses_a, 1);
    chk("t3_hits", stat_hits_a, 2);

    // 4: wrap from 0x7FF to 0x000 and hit the probe limit
    mem[11'h7FF] = ent(1'b1, 32'h1234_5678, 48'h1, 48'h2);
    mem[11'h000] = ent(1'b1, 32'h1234_5679, 48'h1, 48'h2);
    mem[11'h001] = ent(1'b1, 32'h1234_567A, 48'h1, 48'h2);
    mem[11'h002] = ent(1'b1, 32'h1234_567B, 48'h1, 48'h2);
    lookup_a(32'h0007_F807, 4'h9);
    chk("t4_latency", lat, 9);
    chk("t4_nprobe_en", seen.size(), 4);
    chk("t4_addr0", seen[0], 11'h7FF);
    chk("t4_addr1", seen[1], 11'h000);
    chk("t4_addr2", seen[2], 11'h001);
    chk("t4_addr3", seen[3], 11'h002);
    chk("t4_hit", rsp_hit_a, 0);
    chk("t4_status", rsp_status_a, 2'b10);
    chk("t4_probes", rsp_probes_a, 4);
    chk("t4_dst", rsp_dst_mac_a, 0);
    ack_a(1'b0);
    chk("t4_misses", stat_misses_a, 2);

    // 5: backpressure holds the response, stats move once on handshake
    mem[5] = ent(1'b1, 32'h0A00_0005, 48'hC0C1_C2C3_C4C5, 48'hD0D1_D2D3_D4D5);
    lookup_a(32'h0A00_0005, 4'hA);
    chk("t5_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", rsp_valid_a, 1);
      chk("t5_hold_hit", rsp_hit_a, 1);
      chk("t5_hold_status", rsp_status_a, 2'b00);
      chk("t5_hold_tag", rsp_tag_a, 4'hA);
      chk("t5_hold_dst", rsp_dst_mac_a, 48'hC0C1_C2C3_C4C5);
      chk("t5_hold_src", rsp_src_mac_a, 48'hD0D1_D2D3_D4D5);
      chk("t5_hold_req_ready", req_ready_a, 0);
      chk("t5_hold_hits", stat_hits_a, 2);
      tick;
    end
    ack_a(1'b0);
    chk("t5_hits", stat_hits_a, 3);
    lookup_a(32'h0A00_0005, 4'hB);
    ack_a(1'b1);
    chk("t5_clear_hits", stat_hits_a, 0);
    chk("t5_clear_misses", stat_misses_a, 0);

    // 6: latency-3 instance, reset during WAIT
    lookup_b(32'h0A00_0005, 4'h5);
    chk("t6_pre_latency", lat, 5);
    chk("t6_pre_hit", rsp_hit_b, 1);
    rsp_ready_b = 1'b1;
    tick;
    rsp_ready_b = 1'b0;
    chk("t6_pre_hits", stat_hits_b, 1);
    req_ip_b = 32'h0A00_0005; req_tag_b = 4'h6; req_valid_b = 1'b1;
    tick;
    req_valid_b = 1'b0;
    chk("t6_issue_en", bram_en_b, 1);
    tick;
    chk("t6_wait_en", bram_en_b, 0);
    chk("t6_wait_req_ready", req_ready_b, 0);
    rstn_b = 1'b0;
    tick;
    chk("t6_rst_en", bram_en_b, 0);
    chk("t6_rst_valid", rsp_valid_b, 0);
    chk("t6_rst_hits", stat_hits_b, 0);
    chk("t6_rst_misses", stat_misses_b, 0);
    rstn_b = 1'b1;
    tick;
    chk("t6_rel_req_ready", req_ready_b, 1);
    repeat (6) tick;
    chk("t6_idle_valid", rsp_valid_b, 0);
    chk("t6_idle_en", bram_en_b, 0);
    chk("t6_idle_hits", stat_hits_b, 0);
    lookup_b(32'h0A00_0005, 4'hC);
    chk("t6_latency", lat, 5);
    chk("t6_hit", rsp_hit_b, 1);
    chk("t6_probes", rsp_probes_b, 1);
    chk("t6_tag", rsp_tag_b, 4'hC);
    chk("t6_dst", rsp_dst_mac_b, 48'hC0C1_C2C3_C4C5);
    rsp_ready_b = 1'b1;
    tick;
    rsp_ready_b = 1'b0;
    chk("t6_hits", stat_hits_b, 1);
    chk("t6_req_ready", req_ready_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
